wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid  input  1  MEM->WB payload valid (driven by MEM's WB_signal_valid).
REQ-005 signal  input  70  MEM->WB payload: [69:38] pc, [37] rf_we, [36:32] rf_waddr, [31:0] final_result.
REQ-006 WB_allowin  output  1  WB can accept a payload this cycle.
REQ-007 raddr1  input  5  register file read address, port 1.
REQ-008 raddr2  input  5  register file read address, port 2.
REQ-009 rdata1  output  32  read data, port 1.
REQ-010 rdata2  output  32  read data, port 2.
REQ-011 wb_dest  output  5  destination register of the in-flight WB instruction, for hazard detection.
REQ-012 debug_wb_pc  output  32  pc of the WB instruction.
REQ-013 debug_wb_rf_we  output  4  register write byte enables for the trace.
REQ-014 debug_wb_rf_wnum  output  5  register number written.
REQ-015 debug_wb_rf_wdata  output  32  register write data.

Function
REQ-016 The block SHALL hold a WB pipeline register: WB_valid (1 bit) plus the 70-bit payload.
REQ-017 WB_readygo SHALL be constant 1, and WB_allowin SHALL equal !WB_valid || WB_readygo, which is 1 outside reset.
REQ-018 When WB_allowin=1 at an edge, WB_valid SHALL load valid.
REQ-019 The payload register SHALL load signal only when valid && WB_allowin; on a bubble (valid=0) the payload fields hold their old value.
REQ-020 Latency: a payload presented with valid=1 in cycle N SHALL appear on the debug outputs in cycle N+1.
REQ-021 Register write SHALL occur at the edge ending cycle N+1 iff WB_valid && rf_we && rf_waddr!=0.
REQ-022 The register file SHALL hold 32 x 32-bit registers; r0 SHALL always read 0, and writes to r0 are discarded.
REQ-023 Reads SHALL be combinational; raddrX==0 SHALL return 0.
REQ-024 Write-through: when a write is active this cycle and raddrX==rf_waddr!=0, rdataX SHALL return final_result instead of the stored value; both ports bypass independently.
REQ-025 debug_wb_rf_we SHALL equal {4{WB_valid && rf_we}}, and debug_wb_rf_wnum and debug_wb_rf_wdata SHALL equal rf_waddr and final_result.
REQ-026 debug_wb_rf_we SHALL assert for rf_waddr=0 even though no register changes, so that the trace matches the reference trace.
REQ-027 wb_dest SHALL equal rf_waddr when WB_valid && rf_we, and 0 otherwise.
REQ-028 Back-to-back payloads on consecutive cycles SHALL each be written exactly once, in order, with no stall.

Reset
REQ-029 At a reset edge, WB_valid, the payload register and all 32 registers SHALL clear to 0.
REQ-030 No register file write SHALL occur at a reset edge, even if a write was pending.
REQ-031 During reset, all debug outputs, wb_dest, rdata1 and rdata2 SHALL read 0.
REQ-032 WB_allowin SHALL be 0 while reset=1 and 1 from the first cycle after reset deasserts.
REQ-033 valid presented while reset=1 SHALL be dropped.

Verification
REQ-034 Basic write: valid=1, pc=0x1c000000, rf_we=1, rf_waddr=5, result=0xDEADBEEF -> next cycle debug_wb_pc=0x1c000000, debug_wb_rf_we=4'hF, wnum=5; raddr1=5 then returns 0xDEADBEEF in that cycle (bypass) and in all later cycles (stored).
REQ-035 r0 guard: write 0x12345678 to r0 -> debug_wb_rf_we=4'hF, and raddr1=0 returns 0 in that cycle and all later cycles.
REQ-036 Back-to-back: writes r3=1, r3=2, r4=3 on consecutive cycles -> afterwards r3=2 and r4=3, with three trace entries in order.
REQ-037 Bubble: payload with valid=0 -> debug_wb_rf_we=0, wb_dest=0, and no register changes.
REQ-038 Reset mid-operation: assert reset in the same cycle as a pending write to r7=0xAA -> r7 reads 0 after reset, and WB_valid=0.
REQ-039 rf_we=0 payload: debug_wb_rf_we=0 and wb_dest=0, but debug_wb_pc updates.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM->WB handshake bundle.
//   valid      : payload valid from MEM
//   signal     : 70-bit payload {pc[31:0], rf_we, rf_waddr[4:0], final_result[31:0]}
//   WB_allowin : WB can accept a payload this cycle
interface wb_stage_if;
  localparam int unsigned PAYLOAD_W = 70;

  logic                 valid;
  logic [PAYLOAD_W-1:0] signal;
  logic                 WB_allowin;

  modport master (output valid, output signal, input  WB_allowin);
  modport slave  (input  valid, input  signal, output WB_allowin);
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: WB pipeline register, 32x32 register file with
// write-through read ports, hazard destination and debug trace outputs.
//   clk, reset          : clock, synchronous active-high reset
//   mem_wb (slave)      : valid / signal in, WB_allowin out
//   raddr1/2, rdata1/2  : combinational register file read ports
//   wb_dest             : destination of the in-flight writing instruction
//   debug_wb_*          : retirement trace (pc, byte enables, reg num, data)
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   mem_wb,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [4:0]  wb_dest,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_N   = 32;
  localparam int unsigned REG_AW  = 5;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   final_result;
  } wb_payload_t;

  logic            wb_valid;
  wb_payload_t     wb_payload;
  logic [XLEN-1:0] rf [REG_N];

  logic wb_readygo_c;
  logic wb_allowin_c;
  logic wb_fire_c;   // valid instruction that requests a write (trace view)
  logic rf_wen_c;    // write that actually changes the register file

  // WB never stalls; acceptance is only blocked by reset.
  assign wb_readygo_c = 1'b1;
  assign wb_allowin_c = !reset && (!wb_valid || wb_readygo_c);
  assign mem_wb.WB_allowin = wb_allowin_c;

  assign wb_fire_c = wb_valid && wb_payload.rf_we;
  assign rf_wen_c  = !reset && wb_fire_c && (wb_payload.rf_waddr != REG_AW'(0));

  // Pipeline register; payload holds its value across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_payload <= '0;
    end else begin
      if (wb_allowin_c) begin
        wb_valid <= mem_wb.valid;
      end
      if (mem_wb.valid && wb_allowin_c) begin
        wb_payload <= wb_payload_t'(mem_wb.signal);
      end
    end
  end

  // Register file; r0 is never written so it stays 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_N); i++) begin
        rf[i] <= '0;
      end
    end else if (rf_wen_c) begin
      rf[wb_payload.rf_waddr] <= wb_payload.final_result;
    end
  end

  // Read port 1 with write-through of the retiring result.
  always_comb begin
    rdata1 = '0;
    if (!reset && (raddr1 != REG_AW'(0))) begin
      if (rf_wen_c && (raddr1 == wb_payload.rf_waddr)) begin
        rdata1 = wb_payload.final_result;
      end else begin
        rdata1 = rf[raddr1];
      end
    end
  end

  // Read port 2 with write-through of the retiring result.
  always_comb begin
    rdata2 = '0;
    if (!reset && (raddr2 != REG_AW'(0))) begin
      if (rf_wen_c && (raddr2 == wb_payload.rf_waddr)) begin
        rdata2 = wb_payload.final_result;
      end else begin
        rdata2 = rf[raddr2];
      end
    end
  end

  // Trace and hazard outputs; forced to 0 while reset is held.
  // The trace byte enables follow rf_we even for r0 to match the golden trace.
  always_comb begin
    wb_dest           = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (!reset) begin
      wb_dest           = wb_fire_c ? wb_payload.rf_waddr : REG_AW'(0);
      debug_wb_pc       = wb_payload.pc;
      debug_wb_rf_we    = {4{wb_fire_c}};
      debug_wb_rf_wnum  = wb_payload.rf_waddr;
      debug_wb_rf_wdata = wb_payload.final_result;
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic [4:0]  wb_dest;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int errors = 0;
  int checks = 0;

  wb_stage_if bus ();

  wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .mem_wb           (bus),
    .raddr1           (raddr1),
    .raddr2           (raddr2),
    .rdata1           (rdata1),
    .rdata2           (rdata2),
    .wb_dest          (wb_dest),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_we   (debug_wb_rf_we),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  // Reference model: architectural registers plus the instruction held in WB.
  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0;
  logic [69:0] m_pay   = '0;

  function automatic logic [69:0] mk(input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {pc, we, wa, res};
  endfunction

  // Expected read value: 0 in reset or for r0, the retiring value if it is
  // being written to that register now, else the architectural value.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [4:0] wa;
    wa = m_pay[36:32];
    if (reset || a == 5'd0) return 32'd0;
    if (m_valid && m_pay[37] && wa != 5'd0 && a == wa) return m_pay[31:0];
    return m_rf[a];
  endfunction

  task automatic set_in(input logic v, input logic [69:0] s, input logic r);
    bus.valid  = v;
    bus.signal = s;
    reset      = r;
    #1;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      foreach (m_rf[i]) m_rf[i] = 32'd0;
      m_valid = 1'b0;
      m_pay   = '0;
    end else begin
      if (m_valid && m_pay[37] && m_pay[36:32] != 5'd0) m_rf[m_pay[36:32]] = m_pay[31:0];
      m_valid = bus.valid;
      if (bus.valid) m_pay = bus.signal;
    end
    #1;
  endtask

  task automatic test_reset();
    raddr1 = 5'd3; raddr2 = 5'd17;
    set_in(1'b1, mk(32'h1c00_0040, 1'b1, 5'd3, 32'h5555_aaaa), 1'b1);
    tick();
    set_in(1'b1, mk(32'h1c00_0044, 1'b1, 5'd3, 32'h1111_2222), 1'b1);
    checks++; if (bus.WB_allowin !== 1'b0) begin errors++; $display("FAIL reset_allowin: got %b want 0", bus.WB_allowin); end
    checks++; if (debug_wb_rf_we !== 4'h0 || debug_wb_pc !== 32'd0 || wb_dest !== 5'd0) begin
      errors++; $display("FAIL reset_dbg: we=%h pc=%h dest=%0d want 0", debug_wb_rf_we, debug_wb_pc, wb_dest); end
    checks++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      errors++; $display("FAIL reset_rdata: got %h %h want 0", rdata1, rdata2); end
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++; if (bus.WB_allowin !== 1'b1) begin errors++; $display("FAIL post_reset_allowin: got %b want 1", bus.WB_allowin); end
    checks++; if (debug_wb_rf_we !== 4'h0 || debug_wb_pc !== 32'd0) begin
      errors++; $display("FAIL reset_drop_valid: we=%h pc=%h want 0", debug_wb_rf_we, debug_wb_pc); end
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rf_clear: got %h want 0", rdata1); end
  endtask

  task automatic test_basic_write();
    set_in(1'b1, mk(32'h1c00_0000, 1'b1, 5'd5, 32'hdead_beef), 1'b0);
    tick();
    raddr1 = 5'd5;
    set_in(1'b0, '0, 1'b0);
    checks++; if (debug_wb_pc !== 32'h1c00_0000 || debug_wb_rf_we !== 4'hf || debug_wb_rf_wnum !== 5'd5) begin
      errors++; $display("FAIL basic_trace: pc=%h we=%h wnum=%0d want 1c000000 f 5", debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum); end
    checks++; if (wb_dest !== 5'd5) begin errors++; $display("FAIL basic_dest: got %0d want 5", wb_dest); end
    checks++; if (rdata1 !== 32'hdead_beef) begin errors++; $display("FAIL basic_bypass: got %h want deadbeef", rdata1); end
    tick();
    checks++; if (rdata1 !== 32'hdead_beef) begin errors++; $display("FAIL basic_stored: got %h want deadbeef", rdata1); end
    tick();
    checks++; if (rdata1 !== 32'hdead_beef) begin errors++; $display("FAIL basic_stored2: got %h want deadbeef", rdata1); end
  endtask

  task automatic test_r0_guard();
    set_in(1'b1, mk(32'h1c00_0004, 1'b1, 5'd0, 32'h1234_5678), 1'b0);
    tick();
    raddr1 = 5'd0; raddr2 = 5'd0;
    set_in(1'b0, '0, 1'b0);
    checks++; if (debug_wb_rf_we !== 4'hf || debug_wb_rf_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL r0_trace: we=%h wdata=%h want f 12345678", debug_wb_rf_we, debug_wb_rf_wdata); end
    checks++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      errors++; $display("FAIL r0_bypass: got %h %h want 0", rdata1, rdata2); end
    tick();
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL r0_stored: got %h want 0", rdata1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    logic [4:0]  wn  [3];
    logic [31:0] wd  [3];
    pcs = '{32'h1c00_0100, 32'h1c00_0104, 32'h1c00_0108};
    wn  = '{5'd3, 5'd3, 5'd4};
    wd  = '{32'd1, 32'd2, 32'd3};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, mk(pcs[i], 1'b1, wn[i], wd[i]), 1'b0);
      if (i > 0) begin
        checks++; if (debug_wb_pc !== pcs[i-1] || debug_wb_rf_wnum !== wn[i-1] || debug_wb_rf_wdata !== wd[i-1] || debug_wb_rf_we !== 4'hf) begin
          errors++; $display("FAIL b2b_trace%0d: pc=%h wnum=%0d wdata=%h we=%h want %h %0d %h f",
                             i-1, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, debug_wb_rf_we, pcs[i-1], wn[i-1], wd[i-1]); end
      end
      checks++; if (bus.WB_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin%0d: got %b want 1", i, bus.WB_allowin); end
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    checks++; if (debug_wb_pc !== pcs[2] || debug_wb_rf_wnum !== wn[2] || debug_wb_rf_wdata !== wd[2]) begin
      errors++; $display("FAIL b2b_trace2: pc=%h wnum=%0d wdata=%h want %h %0d %h", debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata, pcs[2], wn[2], wd[2]); end
    tick();
    raddr1 = 5'd3; raddr2 = 5'd4;
    #1;
    checks++; if (rdata1 !== 32'd2 || rdata2 !== 32'd3) begin
      errors++; $display("FAIL b2b_final: r3=%h r4=%h want 2 3", rdata1, rdata2); end
  endtask

  task automatic test_bubble();
    raddr1 = 5'd3; raddr2 = 5'd9;
    set_in(1'b0, mk(32'hffff_0000, 1'b1, 5'd3, 32'hbad0_bad0), 1'b0);
    tick();
    checks++; if (debug_wb_rf_we !== 4'h0 || wb_dest !== 5'd0) begin
      errors++; $display("FAIL bubble_trace: we=%h dest=%0d want 0 0", debug_wb_rf_we, wb_dest); end
    checks++; if (debug_wb_pc !== 32'h1c00_0108) begin errors++; $display("FAIL bubble_hold: pc=%h want 1c000108", debug_wb_pc); end
    tick();
    checks++; if (rdata1 !== 32'd2 || rdata2 !== 32'd0) begin
      errors++; $display("FAIL bubble_noreg: r3=%h r9=%h want 2 0", rdata1, rdata2); end
  endtask

  task automatic test_rf_we0();
    raddr1 = 5'd6;
    set_in(1'b1, mk(32'h1c00_0200, 1'b0, 5'd6, 32'h0000_0666), 1'b0);
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++; if (debug_wb_rf_we !== 4'h0 || wb_dest !== 5'd0) begin
      errors++; $display("FAIL nowe_trace: we=%h dest=%0d want 0 0", debug_wb_rf_we, wb_dest); end
    checks++; if (debug_wb_pc !== 32'h1c00_0200) begin errors++; $display("FAIL nowe_pc: got %h want 1c000200", debug_wb_pc); end
    tick();
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL nowe_noreg: r6=%h want 0", rdata1); end
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, mk(32'h1c00_0300, 1'b1, 5'd7, 32'h0000_00aa), 1'b0);
    tick();
    raddr1 = 5'd7; raddr2 = 5'd4;
    set_in(1'b1, mk(32'h1c00_0304, 1'b1, 5'd8, 32'h0000_00bb), 1'b1);
    checks++; if (rdata1 !== 32'd0 || debug_wb_rf_we !== 4'h0 || bus.WB_allowin !== 1'b0) begin
      errors++; $display("FAIL midreset_during: r7=%h we=%h allowin=%b want 0 0 0", rdata1, debug_wb_rf_we, bus.WB_allowin); end
    tick();
    set_in(1'b0, '0, 1'b0);
    checks++; if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
      errors++; $display("FAIL midreset_rf: r7=%h r4=%h want 0 0", rdata1, rdata2); end
    checks++; if (debug_wb_rf_we !== 4'h0 || debug_wb_pc !== 32'd0) begin
      errors++; $display("FAIL midreset_valid: we=%h pc=%h want 0 0", debug_wb_rf_we, debug_wb_pc); end
  endtask

  task automatic test_random();
    logic        r, v, act;
    logic [69:0] s;
    logic [4:0]  wa;
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = mk($urandom, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
      raddr1 = 5'($urandom_range(0, 7));
      raddr2 = ($urandom_range(0, 1) == 1) ? m_pay[36:32] : 5'($urandom_range(0, 31));
      set_in(v, s, r);
      act = !r && m_valid && m_pay[37];
      wa  = r ? 5'd0 : m_pay[36:32];
      checks++; if (bus.WB_allowin !== !r) begin errors++; $display("FAIL rnd_allowin c%0d: got %b want %b", c, bus.WB_allowin, !r); end
      checks++; if (debug_wb_pc !== (r ? 32'd0 : m_pay[69:38])) begin
        errors++; $display("FAIL rnd_pc c%0d: got %h want %h", c, debug_wb_pc, r ? 32'd0 : m_pay[69:38]); end
      checks++; if (debug_wb_rf_we !== {4{act}} || debug_wb_rf_wnum !== wa) begin
        errors++; $display("FAIL rnd_we c%0d: we=%h wnum=%0d want %h %0d", c, debug_wb_rf_we, debug_wb_rf_wnum, {4{act}}, wa); end
      checks++; if (debug_wb_rf_wdata !== (r ? 32'd0 : m_pay[31:0])) begin
        errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, debug_wb_rf_wdata, r ? 32'd0 : m_pay[31:0]); end
      checks++; if (wb_dest !== (act ? wa : 5'd0)) begin
        errors++; $display("FAIL rnd_dest c%0d: got %0d want %0d", c, wb_dest, act ? wa : 5'd0); end
      checks++; if (rdata1 !== exp_rd(raddr1)) begin
        errors++; $display("FAIL rnd_rdata1 c%0d: a=%0d got %h want %h", c, raddr1, rdata1, exp_rd(raddr1)); end
      checks++; if (rdata2 !== exp_rd(raddr2)) begin
        errors++; $display("FAIL rnd_rdata2 c%0d: a=%0d got %h want %h", c, raddr2, rdata2, exp_rd(raddr2)); end
      tick();
    end
  endtask

  initial begin
    foreach (m_rf[i]) m_rf[i] = 32'd0;
    reset = 1'b1; bus.valid = 1'b0; bus.signal = '0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    #1;
    test_reset();
    test_basic_write();
    test_r0_guard();
    test_back_to_back();
    test_bubble();
    test_rf_we0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
